core_data_mem_responder: RTL and testbench



---
 rtl/pulp_cluster_package.sv | 32 +++
 rtl/core_data_resp_pipe.sv | 41 ++++
 rtl/core_data_mem_responder.sv | 127 ++++++++++++
 tb/tb_core_data_mem_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulp_cluster_package.sv
// rtl/pulp_cluster_package.sv - core data port types and responder helpers
// Purpose: shared request/response structs for the core data port, plus the
//          default error read data and the response pipeline stage record.
// Ports:   none (package).
package pulp_cluster_package;

  // Initiator -> responder. wen=1 means read.
  typedef struct packed {
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [31:0] data;
    logic [3:0]  be;
  } core_data_req_t;

  // Responder -> initiator.
  typedef struct packed {
    logic        gnt;
    logic [31:0] r_data;
    logic        r_valid;
  } core_data_rsp_t;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADA_CCE5;

  // One slot of the response delay line.
  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        err;
  } resp_stage_t;

endpackage

// File: rtl/core_data_resp_pipe.sv
// rtl/core_data_resp_pipe.sv - fixed-latency response delay line
// Purpose: LATENCY-deep shift register of resp_stage_t. Stage 0 loads every
//          cycle from stage_i; stage_o is the last stage.
// Ports:   clk_i   clock
//          rst_i   synchronous active-high reset, clears every stage
//          stage_i response record entering stage 0
//          stage_o response record leaving the last stage
module core_data_resp_pipe
  import pulp_cluster_package::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  resp_stage_t stage_i,
  output resp_stage_t stage_o
);

  resp_stage_t stage_q [LATENCY];
  resp_stage_t stage_d [LATENCY];

  always_comb begin
    stage_d[0] = stage_i;
    for (int i = 1; i < int'(LATENCY); i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(LATENCY); i++) begin
      if (rst_i) begin
        stage_q[i] <= '0;
      end else begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign stage_o = stage_q[LATENCY-1];

endmodule

// File: rtl/core_data_mem_responder.sv
// rtl/core_data_mem_responder.sv - scratchpad responder for the core data port
// Purpose: word-organised memory with byte-enable writes, fixed response
//          latency and deterministic grant stalls modelling bank conflicts.
// Ports:   clk_i  clock
//          rst_i  synchronous active-high reset
//          req_i  request from initiator (req/add/wen/data/be, wen=1 read)
//          rsp_o  response to initiator (gnt/r_data/r_valid)
//          err_o  high with r_valid when the access was out of range
module core_data_mem_responder
  import pulp_cluster_package::*;
#(
  parameter int unsigned NB_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned STALL_EVERY = 0,
  parameter logic [31:0] ERR_RDATA   = ERR_RDATA_DEFAULT
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  core_data_req_t req_i,
  output core_data_rsp_t rsp_o,
  output logic           err_o
);

  localparam int unsigned AW        = $clog2(NB_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(NB_WORDS) << 2;
  // Keep at least one bit so the counter exists even with stalls disabled.
  localparam int unsigned CW        = (STALL_EVERY > 0) ? $clog2(STALL_EVERY + 1) : 1;
  localparam logic [CW-1:0] STALL_MAX = CW'(STALL_EVERY);

  logic [31:0]   mem_q [NB_WORDS];
  logic          stall_q, stall_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;

  logic          gnt;
  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] idx;
  resp_stage_t   stage_in, stage_out;
  logic          unused_addr_lsbs;

  assign gnt      = req_i.req & ~stall_q & ~rst_i;
  // Unsigned subtraction wraps addresses below BASE_ADDR to huge offsets,
  // so a single compare covers both ends of the window.
  assign offset   = req_i.add - BASE_ADDR;
  assign in_range = offset < MEM_BYTES;
  assign idx      = offset[AW+1:2];
  assign unused_addr_lsbs = ^offset[1:0];

  always_ff @(posedge clk_i) begin
    if (gnt && in_range && !req_i.wen) begin
      for (int k = 0; k < 4; k++) begin
        if (req_i.be[k]) begin
          mem_q[idx][8*k +: 8] <= req_i.data[8*k +: 8];
        end
      end
    end
  end

  // Stall fires for exactly one cycle after the STALL_EVERY-th accept; idle
  // cycles hold the count.
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    cnt_d   = cnt_q;
    stall_d = 1'b0;
    if ((STALL_EVERY != 0) && gnt) begin
      if (cnt_inc == STALL_MAX) begin
        cnt_d   = '0;
        stall_d = 1'b1;
      end else begin
        cnt_d   = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    stage_in       = '0;
    stage_in.valid = gnt;
    stage_in.err   = gnt & ~in_range;
    if (gnt) begin
      if (!in_range) begin
        stage_in.rdata = ERR_RDATA;
      end else if (req_i.wen) begin
        stage_in.rdata = mem_q[idx];
      end
    end
  end

  core_data_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_resp_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .stage_i (stage_in),
    .stage_o (stage_out)
  );

  // Outputs are forced quiet while reset is asserted, before the pipeline
  // has been cleared by the reset edge.
  always_comb begin
    rsp_o         = '0;
    rsp_o.gnt     = gnt;
    rsp_o.r_valid = stage_out.valid & ~rst_i;
    rsp_o.r_data  = rsp_o.r_valid ? stage_out.rdata : 32'h0;
    err_o         = rsp_o.r_valid & stage_out.err;
  end

`ifndef SYNTHESIS
  // A stalled request must hold its payload until granted.
  req_stable_a : assert property (@(posedge clk_i) disable iff (rst_i)
    (req_i.req && !rsp_o.gnt) |=>
      (!req_i.req || $stable({req_i.add, req_i.wen, req_i.data, req_i.be})));
`endif

endmodule

// File: tb/tb_core_data_mem_responder.sv
// tb/tb_core_data_mem_responder.sv - directed self-checking bench for the responder
module tb_core_data_mem_responder;
  import pulp_cluster_package::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  core_data_req_t req_a, req_b, req_c, req_d;
  core_data_rsp_t rsp_a, rsp_b, rsp_c, rsp_d;
  logic           err_a, err_b, err_c, err_d;
  logic           rst_a, rst_b, rst_c, rst_d;

  int errors = 0;
  int checks = 0;

  core_data_mem_responder u_dut_a (
    .clk_i (clk), .rst_i (rst_a), .req_i (req_a), .rsp_o (rsp_a), .err_o (err_a)
  );
  core_data_mem_responder #(.LATENCY(3)) u_dut_b (
    .clk_i (clk), .rst_i (rst_b), .req_i (req_b), .rsp_o (rsp_b), .err_o (err_b)
  );
  core_data_mem_responder #(.STALL_EVERY(3)) u_dut_c (
    .clk_i (clk), .rst_i (rst_c), .req_i (req_c), .rsp_o (rsp_c), .err_o (err_c)
  );
  core_data_mem_responder #(.LATENCY(2)) u_dut_d (
    .clk_i (clk), .rst_i (rst_d), .req_i (req_d), .rsp_o (rsp_d), .err_o (err_d)
  );

  function automatic core_data_req_t mk(input logic r, input logic [31:0] a,
                                        input logic w, input logic [31:0] d,
                                        input logic [3:0] b);
    core_data_req_t t;
    t.req  = r;
    t.add  = a;
    t.wen  = w;
    t.data = d;
    t.be   = b;
    return t;
  endfunction

  task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    errors++;
    $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int resp;
    logic granted;
    logic [9:0] pat;

    req_a = '0; req_b = '0; req_c = '0; req_d = '0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;

    req_a = mk(1'b1, 32'h1000_0000, 1'b1, 32'h0, 4'hF);
    @(negedge clk);
    checks++; if (rsp_a.gnt !== 1'b0) fail("rst_gnt", rsp_a.gnt, 0);
    checks++; if (rsp_a.r_valid !== 1'b0) fail("rst_rvalid", rsp_a.r_valid, 0);
    checks++; if (rsp_a.r_data !== 32'h0) fail("rst_rdata", rsp_a.r_data, 0);
    checks++; if (err_a !== 1'b0) fail("rst_err", err_a, 0);
    next_cyc();
    next_cyc();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    req_a = '0;

    req_a = mk(1'b1, 32'h1000_0010, 1'b0, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    checks++; if (rsp_a.gnt !== 1'b1) fail("wr_gnt", rsp_a.gnt, 1);
    checks++; if (rsp_a.r_valid !== 1'b0) fail("wr_no_early_rvalid", rsp_a.r_valid, 0);
    next_cyc();
    req_a = mk(1'b1, 32'h1000_0010, 1'b1, 32'h0, 4'hF);
    @(negedge clk);
    checks++; if (rsp_a.gnt !== 1'b1) fail("rd_gnt", rsp_a.gnt, 1);
    checks++; if (rsp_a.r_valid !== 1'b1) fail("wr_rsp_valid", rsp_a.r_valid, 1);
    checks++; if (rsp_a.r_data !== 32'h0) fail("wr_rsp_data", rsp_a.r_data, 0);
    checks++; if (err_a !== 1'b0) fail("wr_rsp_err", err_a, 0);
    next_cyc();
    req_a = mk(1'b1, 32'h1000_0010, 1'b0, 32'h1122_3344, 4'b0101);
    @(negedge clk);
    checks++; if (rsp_a.r_valid !== 1'b1) fail("rd_rsp_valid", rsp_a.r_valid, 1);
    checks++; if (rsp_a.r_data !== 32'hDEAD_BEEF) fail("rd_rsp_data", rsp_a.r_data, 32'hDEAD_BEEF);
    checks++; if (err_a !== 1'b0) fail("rd_rsp_err", err_a, 0);
    checks++; if (rsp_a.gnt !== 1'b1) fail("pw_gnt", rsp_a.gnt, 1);
    next_cyc();
    req_a = mk(1'b1, 32'h1000_0013, 1'b1, 32'h0, 4'hF);
    @(negedge clk);
    checks++; if (rsp_a.r_valid !== 1'b1) fail("pw_rsp_valid", rsp_a.r_valid, 1);
    checks++; if (rsp_a.r_data !== 32'h0) fail("pw_rsp_data", rsp_a.r_data, 0);
    next_cyc();
    req_a = mk(1'b1, 32'h1000_0000, 1'b0, 32'hCAFE_F00D, 4'hF);
    @(negedge clk);
    checks++; if (rsp_a.r_data !== 32'hDE22_BE44) fail("pw_readback", rsp_a.r_data, 32'hDE22_BE44);
    next_cyc();

    req_a = mk(1'b1, 32'h0FFF_FFFC, 1'b1, 32'h0, 4'hF);
    @(negedge clk);
    checks++; if (rsp_a.gnt !== 1'b1) fail("oor_rd_gnt", rsp_a.gnt, 1);
    next_cyc();
    req_a = mk(1'b1, 32'h1000_1000, 1'b0, 32'h0000_0000, 4'hF);
    @(negedge clk);
    checks++; if (rsp_a.gnt !== 1'b1) fail("oor_wr_gnt", rsp_a.gnt, 1);
    checks++; if (rsp_a.r_valid !== 1'b1) fail("oor_rd_rvalid", rsp_a.r_valid, 1);
    checks++; if (err_a !== 1'b1) fail("oor_rd_err", err_a, 1);
    checks++; if (rsp_a.r_data !== 32'hBADA_CCE5) fail("oor_rd_data", rsp_a.r_data, 32'hBADA_CCE5);
    next_cyc();
    req_a = mk(1'b1, 32'h1000_0000, 1'b1, 32'h0, 4'hF);
    @(negedge clk);
    checks++; if (rsp_a.r_valid !== 1'b1) fail("oor_wr_rvalid", rsp_a.r_valid, 1);
    checks++; if (err_a !== 1'b1) fail("oor_wr_err", err_a, 1);
    next_cyc();
    req_a = '0;
    @(negedge clk);
    checks++; if (rsp_a.r_valid !== 1'b1) fail("mem_unchanged_valid", rsp_a.r_valid, 1);
    checks++; if (err_a !== 1'b0) fail("mem_unchanged_err", err_a, 0);
    checks++; if (rsp_a.r_data !== 32'hCAFE_F00D) fail("mem_unchanged_data", rsp_a.r_data, 32'hCAFE_F00D);
    next_cyc();
    @(negedge clk);
    checks++; if (rsp_a.r_valid !== 1'b0) fail("idle_rvalid", rsp_a.r_valid, 0);
    checks++; if (rsp_a.r_data !== 32'h0) fail("idle_rdata", rsp_a.r_data, 0);
    next_cyc();

    for (int i = 0; i < 8; i++) begin
      req_b = mk(1'b1, 32'h1000_0000 + 32'(4*i), 1'b0, 32'hA000_0000 + 32'(i), 4'hF);
      next_cyc();
    end
    req_b = '0;
    repeat (4) next_cyc();
    for (int k = 0; k < 12; k++) begin
      if (k < 8) req_b = mk(1'b1, 32'h1000_0000 + 32'(4*k), 1'b1, 32'h0, 4'hF);
      else       req_b = '0;
      @(negedge clk);
      if (k < 8) begin
        checks++; if (rsp_b.gnt !== 1'b1) fail("l3_gnt", rsp_b.gnt, 1);
      end
      checks++;
      if (rsp_b.r_valid !== (k >= 3 && k <= 10)) fail("l3_rvalid", rsp_b.r_valid, (k >= 3 && k <= 10));
      if (k >= 3 && k <= 10) begin
        checks++;
        if (rsp_b.r_data !== 32'hA000_0000 + 32'(k-3)) fail("l3_rdata", rsp_b.r_data, 32'hA000_0000 + 32'(k-3));
      end
      next_cyc();
    end

    pat = 10'b1110111011;
    n = 0;
    resp = 0;
    for (int k = 0; k < 10; k++) begin
      req_c = mk(1'b1, 32'h1000_0000 + 32'(4*n), 1'b0, 32'(n), 4'hF);
      @(negedge clk);
      checks++; if (rsp_c.gnt !== pat[9-k]) fail("stall_gnt", rsp_c.gnt, pat[9-k]);
      if (rsp_c.r_valid) resp++;
      granted = rsp_c.gnt;
      next_cyc();
      if (granted) n++;
    end
    req_c = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rsp_c.r_valid) resp++;
      next_cyc();
    end
    checks++; if (n !== 8) fail("stall_accepts", n, 8);
    checks++; if (resp !== 8) fail("stall_responses", resp, 8);
    req_c = mk(1'b1, 32'h1000_0100, 1'b0, 32'h1, 4'hF);
    @(negedge clk);
    checks++; if (rsp_c.gnt !== 1'b1) fail("idle_hold_gnt", rsp_c.gnt, 1);
    next_cyc();
    req_c = mk(1'b1, 32'h1000_0104, 1'b0, 32'h2, 4'hF);
    @(negedge clk);
    checks++; if (rsp_c.gnt !== 1'b0) fail("idle_hold_stall", rsp_c.gnt, 0);
    next_cyc();
    @(negedge clk);
    checks++; if (rsp_c.gnt !== 1'b1) fail("idle_hold_regrant", rsp_c.gnt, 1);
    next_cyc();
    req_c = '0;

    req_d = mk(1'b1, 32'h1000_0040, 1'b0, 32'h5A5A_1234, 4'hF);
    next_cyc();
    req_d = mk(1'b1, 32'h1000_0044, 1'b0, 32'h0F0F_0F0F, 4'hF);
    next_cyc();
    req_d = '0;
    repeat (3) next_cyc();
    req_d = mk(1'b1, 32'h1000_0040, 1'b1, 32'h0, 4'hF);
    @(negedge clk);
    checks++; if (rsp_d.gnt !== 1'b1) fail("l2_rd0_gnt", rsp_d.gnt, 1);
    next_cyc();
    req_d = mk(1'b1, 32'h1000_0044, 1'b1, 32'h0, 4'hF);
    @(negedge clk);
    checks++; if (rsp_d.gnt !== 1'b1) fail("l2_rd1_gnt", rsp_d.gnt, 1);
    next_cyc();
    rst_d = 1'b1;
    req_d = mk(1'b1, 32'h1000_0040, 1'b1, 32'h0, 4'hF);
    @(negedge clk);
    checks++; if (rsp_d.gnt !== 1'b0) fail("l2_rst_gnt", rsp_d.gnt, 0);
    checks++; if (rsp_d.r_valid !== 1'b0) fail("l2_rst_rvalid", rsp_d.r_valid, 0);
    checks++; if (rsp_d.r_data !== 32'h0) fail("l2_rst_rdata", rsp_d.r_data, 0);
    next_cyc();
    rst_d = 1'b0;
    req_d = '0;
    @(negedge clk);
    checks++; if (rsp_d.r_valid !== 1'b0) fail("l2_drop1", rsp_d.r_valid, 0);
    next_cyc();
    @(negedge clk);
    checks++; if (rsp_d.r_valid !== 1'b0) fail("l2_drop2", rsp_d.r_valid, 0);
    next_cyc();
    req_d = mk(1'b1, 32'h1000_0040, 1'b1, 32'h0, 4'hF);
    @(negedge clk);
    checks++; if (rsp_d.gnt !== 1'b1) fail("l2_post_gnt", rsp_d.gnt, 1);
    next_cyc();
    req_d = '0;
    @(negedge clk);
    checks++; if (rsp_d.r_valid !== 1'b0) fail("l2_post_wait", rsp_d.r_valid, 0);
    next_cyc();
    @(negedge clk);
    checks++; if (rsp_d.r_valid !== 1'b1) fail("l2_post_rvalid", rsp_d.r_valid, 1);
    checks++; if (rsp_d.r_data !== 32'h5A5A_1234) fail("l2_post_rdata", rsp_d.r_data, 32'h5A5A_1234);
    checks++; if (err_d !== 1'b0) fail("l2_post_err", err_d, 0);
    next_cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
